// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the 16-bit RISC core: sequences fetch/decode/execute/
// memory/write-back, drives datapath strobes, and counts retired instructions.
module multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             irwr,
    output logic             pcwr,
    output logic [1:0]       pc_src,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             regwr,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic [3:0]       alu_op,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_BEQ  = 4'hB;
    localparam logic [3:0] OP_BNE  = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_NOP  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [1:0] PC_INC  = 2'd0;
    localparam logic [1:0] PC_OFFS = 2'd1;
    localparam logic [1:0] PC_JUMP = 2'd2;

    state_t           state_q, state_d;
    logic             run_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;

    // run_q holds off the first fetch until a clock edge has seen rst_n released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        irwr       = 1'b0;
        pcwr       = 1'b0;
        pc_src     = PC_INC;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        regwr      = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 4'h0;
        halted     = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (run_q) begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        irwr    = 1'b1;
                        pcwr    = 1'b1;
                        pc_src  = PC_INC;
                        state_d = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                if (opcode == OP_NOP) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (opcode == OP_HLT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (opcode <= 4'h7) begin
                    alu_op  = opcode;
                    state_d = S_WB;
                end else if (opcode == OP_ADDI) begin
                    alu_src = 1'b1;
                    state_d = S_WB;
                end else if (opcode == OP_LD || opcode == OP_ST) begin
                    alu_src = 1'b1;
                    state_d = S_MEM;
                end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
                    alu_op  = 4'h1;
                    pcwr    = (opcode == OP_BEQ) ? zero : ~zero;
                    pc_src  = PC_OFFS;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    // Only JMP reaches here; NOP and HLT never leave DECODE for EXEC.
                    pcwr    = 1'b1;
                    pc_src  = PC_JUMP;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                if (opcode == OP_LD) begin
                    mem_rd = 1'b1;
                end else begin
                    mem_wr = 1'b1;
                end
                if (mem_ready) begin
                    if (opcode == OP_LD) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                regwr      = 1'b1;
                mem_to_reg = (opcode == OP_LD);
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign cnt_d       = cnt_q + CNT_W'(retire);
    assign state       = state_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle comparison against a step-table model of
// the instruction sequencing, plus directed latency, halt, reset and wrap checks.
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [3:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             irwr;
    logic             pcwr;
    logic [1:0]       pc_src;
    logic             mem_rd;
    logic             mem_wr;
    logic             regwr;
    logic             mem_to_reg;
    logic             alu_src;
    logic [3:0]       alu_op;
    logic             halted;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_count;

    int               n_checks;
    int               n_errors;
    logic [3:0]       model_cnt;
    logic [20:0]      dut_vec;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .irwr        (irwr),
        .pcwr        (pcwr),
        .pc_src      (pc_src),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .regwr       (regwr),
        .mem_to_reg  (mem_to_reg),
        .alu_src     (alu_src),
        .alu_op      (alu_op),
        .halted      (halted),
        .state       (state),
        .instr_count (instr_count)
    );

    assign dut_vec = {irwr, pcwr, pc_src, mem_rd, mem_wr, regwr, mem_to_reg,
                      alu_src, alu_op, halted, state, instr_count};

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model: outputs for a given step of an instruction ----------------
    // step: 0 fetch, 1 decode, 2 execute, 3 memory, 4 write-back, 5 halted
    function automatic logic [20:0] exp_vec(input int step, input logic [3:0] op,
                                            input logic z, input logic rdy,
                                            input logic [3:0] cnt);
        logic       e_irwr, e_pcwr, e_rd, e_wr, e_regwr, e_m2r, e_asrc, e_halt;
        logic [1:0] e_pcsrc;
        logic [3:0] e_aluop;
        e_irwr = 0; e_pcwr = 0; e_rd = 0; e_wr = 0; e_regwr = 0; e_m2r = 0;
        e_asrc = 0; e_halt = 0; e_pcsrc = 0; e_aluop = 0;
        case (step)
            0: begin e_rd = 1; e_irwr = rdy; e_pcwr = rdy; end
            2: begin
                if (op < 8) e_aluop = op;
                else if (op == 8 || op == 9 || op == 10) e_asrc = 1;
                else if (op == 11) begin e_aluop = 1; e_pcwr = z;  e_pcsrc = 1; end
                else if (op == 12) begin e_aluop = 1; e_pcwr = !z; e_pcsrc = 1; end
                else if (op == 13) begin e_pcwr = 1; e_pcsrc = 2; end
            end
            3: begin e_rd = (op == 9); e_wr = (op == 10); end
            4: begin e_regwr = 1; e_m2r = (op == 9); end
            5: e_halt = 1;
            default: ;
        endcase
        return {e_irwr, e_pcwr, e_pcsrc, e_rd, e_wr, e_regwr, e_m2r, e_asrc,
                e_aluop, e_halt, 3'(step), cnt};
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic check_vec(input string name, input logic [20:0] act, input logic [20:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- driver tasks (entered at posedge + 1) ----------------
    task automatic step_cycle(input int step, input logic [3:0] op, input logic z, input logic rdy);
        opcode    = (step == 0) ? 4'($urandom) : op;
        zero      = (step == 2) ? z : 1'($urandom);
        mem_ready = (step == 0 || step == 3) ? rdy : 1'($urandom);
        @(negedge clk);
        check_vec("cycle", dut_vec, exp_vec(step, op, z, rdy, model_cnt));
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic z, input int fw, input int mw);
        for (int i = 0; i < fw; i++) step_cycle(0, op, z, 1'b0);
        step_cycle(0, op, z, 1'b1);
        step_cycle(1, op, z, 1'b0);
        if (op == 4'hE) begin model_cnt++; return; end
        if (op == 4'hF) return;
        step_cycle(2, op, z, 1'b0);
        if (op >= 4'hB) begin model_cnt++; return; end
        if (op == 4'h9 || op == 4'hA) begin
            for (int i = 0; i < mw; i++) step_cycle(3, op, z, 1'b0);
            step_cycle(3, op, z, 1'b1);
            if (op == 4'hA) begin model_cnt++; return; end
        end
        step_cycle(4, op, z, 1'b0);
        model_cnt++;
    endtask

    // Counts cycles from a FETCH until the DUT returns to FETCH (bounded).
    task automatic measure_latency(input string name, input logic [3:0] op,
                                   input int mw, input int exp_cycles);
        int n;
        int waits_left;
        n = 0;
        waits_left = mw;
        opcode = op;
        zero = 1'b1;
        while (n < 30) begin
            mem_ready = 1'b1;
            if (state == 3'd3 && waits_left > 0) begin
                mem_ready = 1'b0;
                waits_left--;
            end
            @(posedge clk);
            #1;
            n++;
            if (state == 3'd0) break;
        end
        check_val(name, n, exp_cycles);
        model_cnt++;
    endtask

    task automatic reset_release();
        @(negedge clk);
        check_vec("rst_hold", dut_vec, 21'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        check_vec("rst_idle", dut_vec, 21'd0);
        @(posedge clk);
        #1;
        model_cnt = 0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check_vec("rst_async", dut_vec, 21'd0);
        reset_release();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        model_cnt = 0;
        rst_n = 1'b0;
        opcode = 4'h0;
        zero = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        apply_reset();

        // ADD: 0,1,2,4,0 with regwr in WB
        run_instr(4'h0, 1'b0, 0, 0);
        check_val("add_count", instr_count, 1);

        // LD with 3 memory wait states
        measure_latency("ld_wait_latency", 4'h9, 3, 8);
        run_instr(4'h9, 1'b0, 0, 3);

        // branches both ways
        run_instr(4'hB, 1'b1, 0, 0);
        run_instr(4'hB, 1'b0, 0, 0);
        run_instr(4'hC, 1'b1, 0, 0);
        run_instr(4'hC, 1'b0, 0, 0);
        check_val("branch_count", instr_count, 7);

        // zero-wait latencies
        measure_latency("lat_nop",  4'hE, 0, 2);
        measure_latency("lat_beq",  4'hB, 0, 3);
        measure_latency("lat_jmp",  4'hD, 0, 3);
        measure_latency("lat_add",  4'h0, 0, 4);
        measure_latency("lat_addi", 4'h8, 0, 4);
        measure_latency("lat_st",   4'hA, 0, 4);
        measure_latency("lat_ld",   4'h9, 0, 5);
        check_val("latency_count", instr_count, 14);

        // randomized instruction stream (no HLT)
        for (int i = 0; i < 150; i++) begin
            run_instr(4'($urandom_range(0, 14)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // HLT: halted for 20 cycles, count frozen, reset leaves HALT
        begin
            logic [3:0] cnt_before;
            cnt_before = model_cnt;
            run_instr(4'hF, 1'b0, 1, 0);
            for (int i = 0; i < 20; i++) step_cycle(5, 4'hF, 1'b0, 1'($urandom));
            check_val("hlt_count", instr_count, int'(cnt_before));
            check_val("hlt_halted", halted, 1);
        end
        apply_reset();
        check_val("post_hlt_state", state, 0);

        // counter wrap: 17 NOPs with a 4-bit counter
        for (int i = 0; i < 17; i++) run_instr(4'hE, 1'b0, 0, 0);
        check_val("wrap_count", instr_count, 1);

        // async reset during an ST memory wait
        step_cycle(0, 4'hA, 1'b0, 1'b1);
        step_cycle(1, 4'hA, 1'b0, 1'b0);
        step_cycle(2, 4'hA, 1'b0, 1'b0);
        step_cycle(3, 4'hA, 1'b0, 1'b0);
        mem_ready = 1'b0;
        #2;
        check_val("st_wait_memwr", mem_wr, 1);
        rst_n = 1'b0;
        #1;
        check_val("st_rst_memwr", mem_wr, 0);
        check_val("st_rst_state", state, 0);
        check_val("st_rst_count", instr_count, 0);
        reset_release();

        run_instr(4'h3, 1'b0, 1, 0);
        check_val("final_count", instr_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
